// File: rtl/polaris_pkg.sv
// rtl/polaris_pkg.sv - shared encodings and defaults for the Polaris fetch unit
package polaris_pkg;

  localparam logic [1:0] ISIZ_NONE = 2'b00;
  localparam logic [1:0] ISIZ_WORD = 2'b10;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/polaris_fetch_queue.sv
// rtl/polaris_fetch_queue.sv - DEPTH-entry FIFO of {pc, instruction} with push/pop/flush
module polaris_fetch_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [31:0]              push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [XLEN-1:0]          head_pc,
  output logic [31:0]              head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]  <= push_pc;
        ins_mem[tail] <= push_instr;
        tail          <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head contents come straight from storage registers, never from the bus.
  assign head_pc    = pc_mem[head];
  assign head_instr = ins_mem[head];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/polaris_fetch.sv
// rtl/polaris_fetch.sv - autonomous prefetcher driving the I bus into a PC-tagged queue
// Optional misaligned-redirect trap: POLARIS_FETCH_MISALIGN_TRAP_EN
module polaris_fetch
  import polaris_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  output logic [XLEN-1:0] iadr_o,
  output logic [1:0]      isiz_o,
  input  logic            iack_i,
  input  logic [31:0]     idat_i,
  output logic            ir_valid_o,
  output logic [31:0]     ir_o,
  output logic [XLEN-1:0] ir_pc_o,
  input  logic            ir_take_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fault_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    resume_state;
  fetch_state_t    drained_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] old_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            q_full;
  logic            q_empty;
  logic            push;
  logic            pop;
  logic            room;

  assign target     = redirect_pc_i & ~XLEN'(3);
  assign push       = (state == ST_REQ) && iack_i && !redirect_i && !q_full;
  assign pop        = ir_take_i && !q_empty && !redirect_i;
  assign count_next = count + CW'(push) - CW'(pop);
  assign room       = (count_next < CW'(DEPTH));

`ifdef POLARIS_FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic fault_q;

  assign misaligned = |redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fault_q <= 1'b0;
    end else if (redirect_i) begin
      fault_q <= misaligned;
    end
  end

  // A trapped redirect still has to drain an outstanding request first.
  assign resume_state  = misaligned ? ST_FAULT : ST_REQ;
  assign drained_state = fault_q ? ST_FAULT : ST_REQ;
  assign fault_o       = fault_q;
`else
  assign resume_state  = ST_REQ;
  assign drained_state = ST_REQ;
  assign fault_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state  <= ST_IDLE;
      pc     <= RESET_VECTOR;
      old_pc <= '0;
    end else if (redirect_i) begin
      pc <= target;
      case (state)
        ST_REQ: begin
          if (iack_i) begin
            state <= resume_state;
          end else begin
            state  <= ST_DISCARD;
            old_pc <= pc;
          end
        end
        // An ack here retires the stale request, so the new target can go out.
        ST_DISCARD: if (iack_i) state <= resume_state;
        default:    state <= resume_state;
      endcase
    end else begin
      case (state)
        ST_IDLE: if (room) state <= ST_REQ;
        ST_REQ: begin
          if (iack_i) begin
            pc <= pc + XLEN'(4);
            if (!room) state <= ST_IDLE;
          end
        end
        ST_DISCARD: if (iack_i) state <= drained_state;
        default: ;
      endcase
    end
  end

  always_comb begin
    iadr_o = '0;
    isiz_o = ISIZ_NONE;
    if (state == ST_REQ) begin
      iadr_o = pc;
      isiz_o = ISIZ_WORD;
    end else if (state == ST_DISCARD) begin
      iadr_o = old_pc;
      isiz_o = ISIZ_WORD;
    end
  end

  polaris_fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .push       (push),
    .push_pc    (pc),
    .push_instr (idat_i),
    .pop        (pop),
    .flush      (redirect_i),
    .head_pc    (ir_pc_o),
    .head_instr (ir_o),
    .count      (count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign ir_valid_o = !q_empty;

endmodule

// File: tb/tb_polaris_fetch.sv
// tb/tb_polaris_fetch.sv - directed self-checking bench for polaris_fetch
module tb_polaris_fetch;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [63:0] iadr_o;
  logic [1:0]  isiz_o;
  logic        iack_i;
  logic [31:0] idat_i;
  logic        ir_valid_o;
  logic [31:0] ir_o;
  logic [63:0] ir_pc_o;
  logic        ir_take_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

  polaris_fetch dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .iadr_o        (iadr_o),
    .isiz_o        (isiz_o),
    .iack_i        (iack_i),
    .idat_i        (idat_i),
    .ir_valid_o    (ir_valid_o),
    .ir_o          (ir_o),
    .ir_pc_o       (ir_pc_o),
    .ir_take_i     (ir_take_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    reset_ni      = 1'b0;
    iack_i        = 1'b0;
    idat_i        = '0;
    ir_take_i     = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_iadr",  iadr_o, 64'h0);
    check("rst_isiz",  isiz_o, 64'h0);
    check("rst_valid", ir_valid_o, 64'h0);
    check("rst_fault", fault_o, 64'h0);
    check("rst_ir",    ir_o, 64'h0);
    check("rst_irpc",  ir_pc_o, 64'h0);
    reset_ni = 1'b1;

    // Request at the reset vector held for 3 unacknowledged cycles.
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_iadr",  iadr_o, RV);
      check("hold_isiz",  isiz_o, 64'h2);
      check("hold_valid", ir_valid_o, 64'h0);
    end

    // Back-to-back fill of all four slots.
    iack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idat_i = 32'h13 + 32'(k) * 32'h100;
      step();
      if (k < 3) check("fill_iadr", iadr_o, RV + 64'(4 * (k + 1)));
      check("fill_valid", ir_valid_o, 64'h1);
      check("fill_irpc",  ir_pc_o, RV);
      check("fill_ir",    ir_o, 64'h13);
    end
    check("full_isiz", isiz_o, 64'h0);
    check("full_iadr", iadr_o, 64'h0);
    iack_i = 1'b0;
    step();
    check("full_stay_isiz", isiz_o, 64'h0);

    // One pop frees a slot; the next request is FF10.
    ir_take_i = 1'b1;
    step();
    ir_take_i = 1'b0;
    check("pop_iadr", iadr_o, RV + 64'h10);
    check("pop_isiz", isiz_o, 64'h2);
    check("pop_irpc", ir_pc_o, RV + 64'h4);
    check("pop_ir",   ir_o, 64'h113);

    // Simultaneous push and pop keeps fetching.
    iack_i    = 1'b1;
    idat_i    = 32'h413;
    ir_take_i = 1'b1;
    step();
    iack_i    = 1'b0;
    ir_take_i = 1'b0;
    check("pp_iadr", iadr_o, RV + 64'h14);
    check("pp_irpc", ir_pc_o, RV + 64'h8);
    check("pp_ir",   ir_o, 64'h213);

    // Redirect to 0x124 while FF14 is outstanding: old address held until ack.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h124;
    step();
    redirect_i = 1'b0;
    check("disc_iadr0", iadr_o, RV + 64'h14);
    check("disc_valid", ir_valid_o, 64'h0);
    step();
    check("disc_iadr1", iadr_o, RV + 64'h14);
    check("disc_isiz",  isiz_o, 64'h2);
    iack_i = 1'b1;
    idat_i = 32'hDEAD_BEEF;
    step();
    check("disc_done_iadr",  iadr_o, 64'h124);
    check("disc_done_valid", ir_valid_o, 64'h0);
    idat_i = 32'h513;
    step();
    check("tgt_valid", ir_valid_o, 64'h1);
    check("tgt_irpc",  ir_pc_o, 64'h124);
    check("tgt_ir",    ir_o, 64'h513);
    check("tgt_iadr",  iadr_o, 64'h128);

    // Redirect to 0x248 coinciding with ack and pop: word dropped, queue empty.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h248;
    idat_i        = 32'h613;
    ir_take_i     = 1'b1;
    step();
    redirect_i = 1'b0;
    ir_take_i  = 1'b0;
    check("rdack_valid", ir_valid_o, 64'h0);
    check("rdack_iadr",  iadr_o, 64'h248);
    check("rdack_isiz",  isiz_o, 64'h2);

    // Misaligned redirect to 0x126, taken together with an ack.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h126;
    step();
    redirect_i = 1'b0;
`ifdef POLARIS_FETCH_MISALIGN_TRAP_EN
    check("mis_fault", fault_o, 64'h1);
    check("mis_isiz",  isiz_o, 64'h0);
    step();
    check("mis_hold_fault", fault_o, 64'h1);
    check("mis_hold_valid", ir_valid_o, 64'h0);
`else
    check("mis_fault", fault_o, 64'h0);
    check("mis_iadr",  iadr_o, 64'h124);
`endif

    // Aligned redirect to 0x128 resumes normal fetch in both builds.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h128;
    step();
    redirect_i = 1'b0;
    iack_i     = 1'b0;
    check("al_fault", fault_o, 64'h0);
    check("al_iadr",  iadr_o, 64'h128);
    check("al_isiz",  isiz_o, 64'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
